bp_update_sched: RTL and testbench
==================================

BP_UPDATE_SCHED -- requirements
Module: bp_update_sched

Interface
REQ-001 SHALL have parameter NUM_IN, default 2: number of branch-resolve update lanes.
REQ-002 SHALL have parameter DEPTH, default 4: update FIFO entries, power of two.
REQ-003 SHALL have parameter NUM_ENTRIES, default 256: predictor table entries swept on clear, power of two.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port IN_btUpdates, input, BTUpdate[NUM_IN]: resolved branch-target updates, each with a valid bit.
REQ-007 SHALL have port IN_clear, input, 1: request a full table clear (icache clear).
REQ-008 SHALL have port IN_mispredFlush, input, 1: discard all queued updates.
REQ-009 SHALL have port IN_wrReady, input, 1: predictor write port accepts this cycle.
REQ-010 SHALL have port OUT_wrValid, output, 1: write request valid.
REQ-011 SHALL have port OUT_wrClr, output, 1: the current write is a clear-sweep write.
REQ-012 SHALL have port OUT_wrIdx, output, log2(NUM_ENTRIES): sweep index, 0 when OUT_wrClr=0.
REQ-013 SHALL have port OUT_wrUpd, output, BTUpdate: head update, valid field = OUT_wrValid && !OUT_wrClr.
REQ-014 SHALL have port OUT_stall, output, 1: fetch stall while sweeping.
REQ-015 SHALL have port OUT_dropCnt, output, 8: saturating count of updates lost to overflow.

Function
REQ-016 SHALL implement FSM states RUN and SWEEP.
REQ-017 SHALL go from RUN or SWEEP to SWEEP when IN_clear=1, with sweep index 0 on the next cycle; a clear during SWEEP restarts at index 0.
REQ-018 SHALL, in SWEEP, drive OUT_wrValid=1, OUT_wrClr=1 and OUT_wrIdx=index, and increment index only when IN_wrReady=1.
REQ-019 SHALL return to RUN on the cycle after the write at index NUM_ENTRIES-1 is accepted; index wraps to 0.
REQ-020 SHALL drive OUT_stall=1 exactly while in SWEEP.
REQ-021 SHALL, in RUN, drive OUT_wrValid=1 when the FIFO is non-empty, with OUT_wrUpd equal to the FIFO head.
REQ-022 SHALL dequeue the FIFO head when OUT_wrValid && !OUT_wrClr && IN_wrReady; OUT_wrUpd SHALL hold stable while not accepted.
REQ-023 SHALL enqueue valid lanes in ascending lane order, up to NUM_IN per cycle.
REQ-024 SHALL compute free slots as DEPTH - count + (dequeue this cycle).
REQ-025 SHALL enqueue the lowest-indexed valid lanes that fit and drop the rest, adding the dropped count to OUT_dropCnt, saturating at 255.
REQ-026 SHALL make queued data visible at the head no earlier than the cycle after enqueue; there is no bypass.
REQ-027 SHALL wrap FIFO read and write pointers modulo DEPTH, with count width log2(DEPTH)+1.
REQ-028 SHALL, on IN_mispredFlush=1, empty the FIFO next cycle and discard same-cycle enqueues; the dequeue handshake in that cycle still completes.
REQ-029 SHALL, on IN_clear=1, empty the FIFO and silently discard updates arriving during SWEEP, without counting them as drops.
REQ-030 SHALL give IN_clear priority over IN_mispredFlush, and the sweep over queued updates.

Reset
REQ-031 SHALL, while rst=1, asynchronously force state RUN, FIFO empty, index 0, OUT_dropCnt 0, OUT_wrValid 0, OUT_wrClr 0, OUT_stall 0 and OUT_wrIdx 0.
REQ-032 SHALL abandon an in-progress sweep on reset and not resume it.

Structure
REQ-033 SHALL take BTUpdate from the shared package; the FSM state enum SHALL be added to that package.
REQ-034 SHALL keep the FIFO in a sub-module named bp_upd_fifo, multi-push with a single pop.

Verification
REQ-035 SHALL test: both lanes valid for 3 cycles, IN_wrReady=0 -> 4 entries queued in lane order, 2 dropped, OUT_dropCnt=2.
REQ-036 SHALL test: FIFO full, IN_wrReady=1, one lane valid -> dequeue and enqueue in the same cycle, no drop, count stays 4.
REQ-037 SHALL test: IN_clear pulse with 3 queued entries -> next cycle OUT_stall=1, OUT_wrIdx=0, FIFO empty, and 256 accepted clear writes return to RUN.
REQ-038 SHALL test: IN_clear at sweep index 100 -> OUT_wrIdx returns to 0 next cycle, and the sweep lasts 256 more accepts.
REQ-039 SHALL test: IN_mispredFlush with an enqueue in the same cycle -> FIFO empty next cycle and OUT_wrValid=0.
REQ-040 SHALL test: rst asserted mid-sweep between clock edges -> all outputs 0 immediately and state RUN after release.

Source files
------------

// File: rtl/bp_update_sched_pkg.sv
// Shared branch-predictor types: resolved branch-target update record and
// the update scheduler's state encoding.
package bp_update_sched_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] src;
        logic [31:0] dst;
        logic        isCall;
    } BTUpdate;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        SWEEP = 1'b1
    } sched_state_e;

endpackage

// File: rtl/bp_upd_fifo.sv
// Multi-push, single-pop update queue. Valid lanes are accepted lowest index
// first into whatever slots are free; the remainder is reported as dropped.
module bp_upd_fifo
    import bp_update_sched_pkg::*;
#(
    parameter int NUM_IN = 2,
    parameter int DEPTH  = 4,
    localparam int LW    = $clog2(NUM_IN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_en,
    input  logic          flush,
    input  BTUpdate       push [NUM_IN],
    input  logic          pop,
    output BTUpdate       head,
    output logic          empty,
    output logic [LW-1:0] drop_num
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    BTUpdate       mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          acc  [NUM_IN];
    logic [PW-1:0] slot [NUM_IN];
    int            free;
    int            n_acc;
    int            n_drop;

    // A slot freed by this cycle's pop can be refilled in the same cycle.
    always_comb begin
        free   = DEPTH - int'(count) + int'(pop);
        n_acc  = 0;
        n_drop = 0;
        for (int i = 0; i < NUM_IN; i++) begin
            acc[i]  = 1'b0;
            slot[i] = '0;
            if (push_en && !flush && push[i].valid) begin
                if (n_acc < free) begin
                    acc[i]  = 1'b1;
                    slot[i] = wr_ptr + PW'(n_acc);
                    n_acc   = n_acc + 1;
                end else begin
                    n_drop = n_drop + 1;
                end
            end
        end
    end

    assign drop_num = LW'(n_drop);
    assign head     = mem[rd_ptr];
    assign empty    = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(pop);
            wr_ptr <= wr_ptr + PW'(n_acc);
            count  <= count + CW'(n_acc) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_IN; i++) begin
            if (acc[i]) begin
                mem[slot[i]] <= push[i];
            end
        end
    end

endmodule

// File: rtl/bp_update_sched.sv
// Schedules the predictor table write port between queued branch-target
// updates and a full-table clear sweep that stalls fetch while it runs.
module bp_update_sched
    import bp_update_sched_pkg::*;
#(
    parameter int NUM_IN      = 2,
    parameter int DEPTH       = 4,
    parameter int NUM_ENTRIES = 256,
    localparam int IW         = $clog2(NUM_ENTRIES)
) (
    input  logic          clk,
    input  logic          rst,
    input  BTUpdate       IN_btUpdates [NUM_IN],
    input  logic          IN_clear,
    input  logic          IN_mispredFlush,
    input  logic          IN_wrReady,
    output logic          OUT_wrValid,
    output logic          OUT_wrClr,
    output logic [IW-1:0] OUT_wrIdx,
    output BTUpdate       OUT_wrUpd,
    output logic          OUT_stall,
    output logic [7:0]    OUT_dropCnt
);

    localparam int LW = $clog2(NUM_IN + 1);

    sched_state_e  state;
    logic [IW-1:0] idx;
    logic          sweep;
    logic          fifo_empty;
    logic          fifo_flush;
    logic          push_en;
    logic          pop;
    BTUpdate       head;
    logic [LW-1:0] drop_num;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [LW-1:0] b);
        int s;
        s = int'(a) + int'(b);
        return (s > 255) ? 8'hFF : 8'(s);
    endfunction

    assign sweep       = (state == SWEEP);
    assign OUT_stall   = sweep;
    assign OUT_wrClr   = sweep;
    assign OUT_wrValid = sweep || !fifo_empty;
    assign OUT_wrIdx   = sweep ? idx : '0;

    always_comb begin
        OUT_wrUpd       = head;
        OUT_wrUpd.valid = OUT_wrValid && !sweep && head.valid;
    end

    // Clearing empties the queue; nothing is accepted while the sweep owns the port.
    assign pop        = !sweep && !fifo_empty && IN_wrReady;
    assign push_en    = !sweep && !IN_clear && !IN_mispredFlush;
    assign fifo_flush = IN_clear || IN_mispredFlush;

    bp_upd_fifo #(
        .NUM_IN (NUM_IN),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_en  (push_en),
        .flush    (fifo_flush),
        .push     (IN_btUpdates),
        .pop      (pop),
        .head     (head),
        .empty    (fifo_empty),
        .drop_num (drop_num)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            idx   <= '0;
        end else if (IN_clear) begin
            state <= SWEEP;
            idx   <= '0;
        end else if (sweep && IN_wrReady) begin
            if (idx == IW'(NUM_ENTRIES - 1)) begin
                state <= RUN;
                idx   <= '0;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            OUT_dropCnt <= '0;
        end else if (drop_num != '0) begin
            OUT_dropCnt <= sat_add(OUT_dropCnt, drop_num);
        end
    end

endmodule

// File: tb/tb_bp_update_sched.sv
// Directed bench for bp_update_sched: a vector table for queueing behaviour
// plus hand sequences for clear sweeps, sweep restart and mid-sweep reset.
module tb_bp_update_sched;
    import bp_update_sched_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    BTUpdate    upd [2];
    logic       clear;
    logic       flush;
    logic       rdy;
    logic       wr_valid;
    logic       wr_clr;
    logic [7:0] wr_idx;
    BTUpdate    wr_upd;
    logic       stall;
    logic [7:0] drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    bp_update_sched dut (
        .clk             (clk),
        .rst             (rst),
        .IN_btUpdates    (upd),
        .IN_clear        (clear),
        .IN_mispredFlush (flush),
        .IN_wrReady      (rdy),
        .OUT_wrValid     (wr_valid),
        .OUT_wrClr       (wr_clr),
        .OUT_wrIdx       (wr_idx),
        .OUT_wrUpd       (wr_upd),
        .OUT_stall       (stall),
        .OUT_dropCnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        v0;
        logic [31:0] d0;
        logic        v1;
        logic [31:0] d1;
        logic        rdy;
        logic        flush;
        logic        e_valid;
        logic [31:0] e_dst;
        logic [7:0]  e_drop;
    } vec_t;

    vec_t tbl [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic BTUpdate mk(input logic v, input logic [31:0] d);
        BTUpdate u;
        u        = '0;
        u.valid  = v;
        u.dst    = d;
        u.src    = 32'h1000 + d;
        u.isCall = d[0];
        return u;
    endfunction

    task automatic run_sweep(input string name, output int acc);
        int cyc;
        acc = 0;
        cyc = 0;
        while (stall === 1'b1 && cyc < 1000) begin
            rdy    = (cyc % 3) != 2;
            upd[0] = mk(1'b1, 32'(cyc));
            upd[1] = mk(1'b1, 32'(cyc + 500));
            #1;
            check({name, "_idx"}, 32'(wr_idx), 32'(acc[7:0]));
            check({name, "_clr"}, 32'(wr_clr), 32'd1);
            if (rdy) acc++;
            step();
            cyc++;
        end
        check({name, "_end_stall"}, 32'(stall), 32'd0);
        upd[0] = mk(1'b0, 32'd0);
        upd[1] = mk(1'b0, 32'd0);
        rdy    = 1'b0;
    endtask

    initial begin
        int acc;

        rst    = 1'b1;
        clear  = 1'b0;
        flush  = 1'b0;
        rdy    = 1'b0;
        upd[0] = mk(1'b0, 32'd0);
        upd[1] = mk(1'b0, 32'd0);

        tbl[0]  = '{1, 32'h11, 1, 32'h12, 0, 0, 0, 32'h0,  8'd0};
        tbl[1]  = '{1, 32'h21, 1, 32'h22, 0, 0, 1, 32'h11, 8'd0};
        tbl[2]  = '{1, 32'h31, 1, 32'h32, 0, 0, 1, 32'h11, 8'd0};
        tbl[3]  = '{0, 32'h0,  0, 32'h0,  0, 0, 1, 32'h11, 8'd2};
        tbl[4]  = '{1, 32'h41, 0, 32'h0,  1, 0, 1, 32'h11, 8'd2};
        tbl[5]  = '{0, 32'h0,  1, 32'h51, 0, 0, 1, 32'h12, 8'd2};
        tbl[6]  = '{0, 32'h0,  0, 32'h0,  1, 0, 1, 32'h12, 8'd3};
        tbl[7]  = '{0, 32'h0,  0, 32'h0,  1, 0, 1, 32'h21, 8'd3};
        tbl[8]  = '{0, 32'h0,  0, 32'h0,  1, 0, 1, 32'h22, 8'd3};
        tbl[9]  = '{0, 32'h0,  0, 32'h0,  1, 0, 1, 32'h41, 8'd3};
        tbl[10] = '{1, 32'h61, 0, 32'h0,  1, 0, 0, 32'h0,  8'd3};
        tbl[11] = '{0, 32'h0,  0, 32'h0,  0, 0, 1, 32'h61, 8'd3};
        tbl[12] = '{1, 32'h71, 0, 32'h0,  1, 1, 1, 32'h61, 8'd3};
        tbl[13] = '{0, 32'h0,  0, 32'h0,  1, 0, 0, 32'h0,  8'd3};
        tbl[14] = '{0, 32'h0,  1, 32'h81, 0, 0, 0, 32'h0,  8'd3};
        tbl[15] = '{1, 32'h91, 0, 32'h0,  0, 0, 1, 32'h81, 8'd3};
        tbl[16] = '{0, 32'h0,  0, 32'h0,  1, 0, 1, 32'h81, 8'd3};
        tbl[17] = '{0, 32'h0,  0, 32'h0,  1, 0, 1, 32'h91, 8'd3};
        tbl[18] = '{0, 32'h0,  0, 32'h0,  1, 0, 0, 32'h0,  8'd3};

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(wr_valid), 32'd0);
        check("rst_clr",   32'(wr_clr),   32'd0);
        check("rst_stall", 32'(stall),    32'd0);
        check("rst_idx",   32'(wr_idx),   32'd0);
        check("rst_drop",  32'(drop_cnt), 32'd0);
        rst = 1'b0;

        for (int r = 0; r < 19; r++) begin
            upd[0] = mk(tbl[r].v0, tbl[r].d0);
            upd[1] = mk(tbl[r].v1, tbl[r].d1);
            rdy    = tbl[r].rdy;
            flush  = tbl[r].flush;
            #1;
            check($sformatf("row%0d_valid", r), 32'(wr_valid), 32'(tbl[r].e_valid));
            check($sformatf("row%0d_updv", r),  32'(wr_upd.valid), 32'(tbl[r].e_valid));
            check($sformatf("row%0d_stall", r), 32'(stall), 32'd0);
            check($sformatf("row%0d_drop", r),  32'(drop_cnt), 32'(tbl[r].e_drop));
            if (tbl[r].e_valid) begin
                check($sformatf("row%0d_dst", r), wr_upd.dst, tbl[r].e_dst);
                check($sformatf("row%0d_src", r), wr_upd.src, 32'h1000 + tbl[r].e_dst);
            end
            step();
        end
        flush  = 1'b0;
        rdy    = 1'b0;
        upd[0] = mk(1'b0, 32'd0);
        upd[1] = mk(1'b0, 32'd0);

        // Three queued entries, then a clear with both lanes still arriving.
        upd[0] = mk(1'b1, 32'hA1);
        upd[1] = mk(1'b1, 32'hA2);
        step();
        upd[1] = mk(1'b0, 32'd0);
        upd[0] = mk(1'b1, 32'hA3);
        step();
        upd[0] = mk(1'b1, 32'hB1);
        upd[1] = mk(1'b1, 32'hB2);
        clear  = 1'b1;
        #1;
        check("preclr_valid", 32'(wr_valid), 32'd1);
        check("preclr_dst",   wr_upd.dst,    32'hA1);
        check("preclr_stall", 32'(stall),    32'd0);
        step();
        clear = 1'b0;
        check("clr_stall", 32'(stall),        32'd1);
        check("clr_clr",   32'(wr_clr),       32'd1);
        check("clr_valid", 32'(wr_valid),     32'd1);
        check("clr_idx",   32'(wr_idx),       32'd0);
        check("clr_updv",  32'(wr_upd.valid), 32'd0);
        run_sweep("sweep1", acc);
        check("sweep1_accepts", 32'(acc), 32'd256);
        check("sweep1_fifo_empty", 32'(wr_valid), 32'd0);
        check("sweep1_drop",  32'(drop_cnt), 32'd3);
        check("sweep1_idx0",  32'(wr_idx),   32'd0);

        // Restart a sweep from index 100.
        clear = 1'b1;
        step();
        clear = 1'b0;
        rdy   = 1'b1;
        repeat (100) step();
        check("restart_pre_idx", 32'(wr_idx), 32'd100);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("restart_idx",   32'(wr_idx), 32'd0);
        check("restart_stall", 32'(stall),  32'd1);
        run_sweep("sweep2", acc);
        check("sweep2_accepts", 32'(acc), 32'd256);

        // Reset between clock edges in the middle of a sweep.
        clear = 1'b1;
        step();
        clear = 1'b0;
        rdy   = 1'b1;
        repeat (20) step();
        check("midrst_pre_idx", 32'(wr_idx), 32'd20);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(wr_valid), 32'd0);
        check("midrst_clr",   32'(wr_clr),   32'd0);
        check("midrst_stall", 32'(stall),    32'd0);
        check("midrst_idx",   32'(wr_idx),   32'd0);
        check("midrst_drop",  32'(drop_cnt), 32'd0);
        #2;
        rst = 1'b0;
        step();
        check("postrst_stall", 32'(stall),    32'd0);
        check("postrst_valid", 32'(wr_valid), 32'd0);
        repeat (3) step();
        check("postrst_stall_later", 32'(stall),  32'd0);
        check("postrst_idx_later",   32'(wr_idx), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
